// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one multicycle 32x32 multiplier between two thread ports.
// Optional MUL_ARB_ZERO_SHORTCUT_EN answers zero-operand requests without starting the multiplier.
module mul_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [31:0] req0_op1,
    input  logic [31:0] req0_op2,
    input  logic        req0_signed,
    output logic        req0_ready,
    input  logic        flush0,
    output logic        resp0_valid,
    output logic [63:0] resp0_result,
    input  logic        req1_valid,
    input  logic [31:0] req1_op1,
    input  logic [31:0] req1_op2,
    input  logic        req1_signed,
    output logic        req1_ready,
    input  logic        flush1,
    output logic        resp1_valid,
    output logic [63:0] resp1_result,
    output logic        mul_start_o,
    output logic        mul_annul_o,
    output logic [31:0] mul_op1_o,
    output logic [31:0] mul_op2_o,
    output logic        mul_signed_o,
    input  logic [63:0] mul_result_i,
    input  logic        mul_ready_i,
    output logic [1:0]  dbg_state
);

    // Handshake: a request transfers on the rising edge where reqN_valid and reqN_ready are both high;
    // respN_valid is a one-cycle pulse with no back-pressure.
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DRAIN = 2'd2} state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        rr_q, rr_d;
    logic        start_d, annul_d, sgn_d;
    logic [31:0] op1_d, op2_d;
    logic        v0_d, v1_d;
    logic [63:0] res0_d, res1_d;
    logic        elig0, elig1, grant_port, flush_own;
    logic [31:0] sel_op1, sel_op2;
    logic        sel_sgn;

    assign dbg_state = state_q;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        start_d    = 1'b0;
        annul_d    = 1'b0;
        op1_d      = mul_op1_o;
        op2_d      = mul_op2_o;
        sgn_d      = mul_signed_o;
        v0_d       = 1'b0;
        v1_d       = 1'b0;
        res0_d     = resp0_result;
        res1_d     = resp1_result;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        elig0      = req0_valid && !flush0;
        elig1      = req1_valid && !flush1;
        grant_port = (elig0 && elig1) ? rr_q : elig1;
        sel_op1    = grant_port ? req1_op1 : req0_op1;
        sel_op2    = grant_port ? req1_op2 : req0_op2;
        sel_sgn    = grant_port ? req1_signed : req0_signed;
        flush_own  = owner_q ? flush1 : flush0;

        case (state_q)
            IDLE: begin
                if (elig0 || elig1) begin
                    req0_ready = !grant_port;
                    req1_ready = grant_port;
                    owner_d    = grant_port;
                    rr_d       = !grant_port;
                    op1_d      = sel_op1;
                    op2_d      = sel_op2;
                    sgn_d      = sel_sgn;
`ifdef MUL_ARB_ZERO_SHORTCUT_EN
                    if (sel_op1 == 32'd0 || sel_op2 == 32'd0) begin
                        if (grant_port) begin
                            v1_d   = 1'b1;
                            res1_d = 64'd0;
                        end else begin
                            v0_d   = 1'b1;
                            res0_d = 64'd0;
                        end
                    end else begin
                        start_d = 1'b1;
                        state_d = BUSY;
                    end
`else
                    start_d = 1'b1;
                    state_d = BUSY;
`endif
                end
            end
            BUSY: begin
                // A flush beats a coincident mul_ready_i: the result is dropped.
                if (flush_own) begin
                    annul_d = 1'b1;
                    state_d = DRAIN;
                end else if (mul_ready_i) begin
                    if (owner_q) begin
                        v1_d   = 1'b1;
                        res1_d = mul_result_i;
                    end else begin
                        v0_d   = 1'b1;
                        res0_d = mul_result_i;
                    end
                    state_d = DRAIN;
                end else begin
                    start_d = 1'b1;
                end
            end
            DRAIN: begin
                if (!mul_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            rr_q         <= 1'b0;
            mul_start_o  <= 1'b0;
            mul_annul_o  <= 1'b0;
            mul_op1_o    <= 32'd0;
            mul_op2_o    <= 32'd0;
            mul_signed_o <= 1'b0;
            resp0_valid  <= 1'b0;
            resp1_valid  <= 1'b0;
            resp0_result <= 64'd0;
            resp1_result <= 64'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_q         <= rr_d;
            mul_start_o  <= start_d;
            mul_annul_o  <= annul_d;
            mul_op1_o    <= op1_d;
            mul_op2_o    <= op2_d;
            mul_signed_o <= sgn_d;
            resp0_valid  <= v0_d;
            resp1_valid  <= v1_d;
            resp0_result <= res0_d;
            resp1_result <= res1_d;
        end
    end

endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

- Shares the single multicycle 32x32 multiplier between two requester ports, one per CPU thread (port 0, port 1).
- Arbitrates requests round-robin, runs the multiplier's start/ready/annul handshake, and returns a 64-bit product to the granted port.
- Handles per-port flushes.
- Sits between the two execute stages and the multiplier instance.

## Interface
Parameters:
- None.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- reqN_valid  in  1  port N (N=0,1) has a multiply pending; held until reqN_ready.
- reqN_op1, reqN_op2  in  32  port N operands; stable while reqN_valid.
- reqN_signed  in  1  port N signed multiply.
- reqN_ready  out  1  one-cycle pulse: port N request accepted, operands latched.
- flushN  in  1  cancel port N's pending or in-flight operation.
- respN_valid  out  1  one-cycle pulse: respN_result valid.
- respN_result  out  64  product for port N; holds last value between pulses.
- mul_start_o  out  1  multiplier start.
- mul_annul_o  out  1  multiplier cancel.
- mul_op1_o, mul_op2_o  out  32  latched operands.
- mul_signed_o  out  1  latched signed flag.
- mul_result_i  in  64  multiplier product.
- mul_ready_i  in  1  multiplier done.

## Operation
States: IDLE, BUSY, DRAIN. Internal registers: owner (1 bit), rr_ptr (1 bit, the port with priority).

IDLE:
- Eligible port: reqN_valid && !flushN.
- Both ports eligible: grant rr_ptr. One port eligible: grant it.
- On grant: pulse reqN_ready; latch op1, op2 and signed onto mul_*_o; set owner; rr_ptr <= ~granted port; go BUSY.

BUSY:
- mul_start_o=1, mul_annul_o=0.
- If flush[owner]: mul_start_o=0 and mul_annul_o=1 for this cycle; go DRAIN; no response.
- Else if mul_ready_i: capture mul_result_i into resp[owner]_result; pulse resp[owner]_valid; go DRAIN.
- flush[owner] together with mul_ready_i: flush wins, no response.

DRAIN:
- mul_start_o=0, mul_annul_o=0.
- Stay until mul_ready_i==0 (minimum one cycle), then go IDLE.
- This guarantees the multiplier sees start low and returns to its idle state before the next start.

Other rules:
- A flush on the non-owner port has no effect on the in-flight operation.
- Flush of either port in IDLE blocks that port's grant that cycle.
- reqN_ready and respN_valid are never high for both ports in the same cycle.
- The product is passed through unmodified: signed is two's-complement 64-bit; unsigned is zero-extended.

## Timing
- Reset: state IDLE; rr_ptr=0; owner=0.
- Reset values: reqN_ready=0, respN_valid=0, respN_result=0, mul_start_o=0, mul_annul_o=0, mul_op1_o=0, mul_op2_o=0, mul_signed_o=0.
- Reset mid-operation: the controller returns to IDLE immediately and no response is issued. The multiplier shares the reset, so both are idle after reset.
- Grant cycle T: reqN_ready is a combinational pulse in IDLE; operands and mul_start_o are registered and valid from T+1.
- respN_valid is asserted in the cycle after mul_ready_i is first sampled high in BUSY.
- All outputs except reqN_ready are registered.
- Back-to-back operations: the next grant is at the earliest one cycle after DRAIN observes mul_ready_i==0.
- Requesters must hold valid, ops and signed until reqN_ready.

## Configuration
MUL_ARB_ZERO_SHORTCUT_EN:
- Defined: in IDLE, a granted request with op1==0 or op2==0 does not start the multiplier. respN_result=0 and respN_valid pulse at T+1. State stays IDLE; rr_ptr still updates.
- Undefined: all requests go through the multiplier. Latency is independent of operand values.

## Test plan
- Unsigned 3 x 5 on port 0:
  - req0_ready pulses once.
  - resp0_valid pulses once with resp0_result=64'h0000_0000_0000_000F.
  - port 1 outputs stay 0.
- Signed port 1, op1=32'hFFFF_FFFE (-2), op2=3 -> resp1_result=64'hFFFF_FFFF_FFFF_FFFA.
- Same operands unsigned on port 1 -> resp1_result=64'h0000_0002_FFFF_FFFA.
- Both ports valid at once after reset, port 0 = 7x9, port 1 = 2x4:
  - port 0 granted first and gets 63.
  - port 1 granted next and gets 8.
  - Repeating with both valid grants port 0 again, because rr_ptr alternates.
- flush0 asserted 5 cycles into a port 0 multiply:
  - mul_annul_o pulses 1 cycle and resp0_valid never fires.
  - A following port 1 request 6x6 returns 36.
- reset asserted mid-BUSY:
  - All outputs are 0 the next cycle.
  - A new 10x10 request returns 100.
- With MUL_ARB_ZERO_SHORTCUT_EN, 0 x 32'hDEAD_BEEF:
  - resp0_valid fires one cycle after grant with result 0.
  - mul_start_o never rises.
